// File: rtl/arbiter_types.sv
// Shared types for the icache/dcache to memory arbiter.
package arbiter_types;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Two-to-one line arbiter: icache and dcache miss ports onto one memory port.
// Data side wins ties unless it won the previous grant.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH = LINE_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t state_q, state_d;
  arb_grant_t last_q, last_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;

  logic d_req;
  logic any_req;
  logic pick_d;

  assign d_req   = d_read | d_write;
  assign any_req = i_read | d_req;
  assign pick_d  = d_req & (~i_read | (last_q == GRANT_I));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = pick_d ? SERVE_D : SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request register: loaded on grant, strobes cleared on completion.
  always_comb begin
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (state_q == IDLE) begin
      if (any_req && pick_d) begin
        last_d  = GRANT_D;
        addr_d  = d_addr;
        wdata_d = d_wdata;
        wr_d    = d_write;
        rd_d    = d_read & ~d_write;
      end else if (any_req) begin
        last_d  = GRANT_I;
        addr_d  = i_addr;
        wdata_d = '0;
        wr_d    = 1'b0;
        rd_d    = 1'b1;
      end
    end else if (mem_resp) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
    end
  end

  always_comb begin
    mem_read  = rd_q;
    mem_write = wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    i_resp    = (state_q == SERVE_I) & mem_resp;
    d_resp    = (state_q == SERVE_D) & mem_resp;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_read = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;

  int passed = 0;
  int total  = 0;

  localparam logic [255:0] LINE_A5 = {32{8'hA5}};
  localparam logic [255:0] LINE_5A = {32{8'h5A}};
  localparam logic [255:0] LINE_WB = {8{32'h12345678}};

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_resp = 1'b1;
    cyc();
    #1;
    total++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0)
      $display("FAIL rst_ctl got %b want 0000",
               {mem_read, mem_write, i_resp, d_resp});
    else passed++;
    total++;
    if (mem_addr !== 32'h0 || mem_wdata !== 256'h0)
      $display("FAIL rst_bus addr %h want 0", mem_addr);
    else passed++;
    mem_resp = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_i_read();
    cyc();
    i_read = 1'b1;
    i_addr = 32'h40;
    #1;
    total++;
    if (mem_read !== 1'b0)
      $display("FAIL i_lat got %b want 0", mem_read);
    else passed++;
    cyc();
    #1;
    total++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h40)
      $display("FAIL i_req rd %b wr %b addr %h want 1 0 40",
               mem_read, mem_write, mem_addr);
    else passed++;
    i_read = 1'b0;
    repeat (4) cyc();
    cyc();
    mem_resp = 1'b1;
    mem_rdata = LINE_A5;
    #1;
    total++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== LINE_A5)
      $display("FAIL i_resp got i %b d %b data %h", i_resp, d_resp, i_rdata);
    else passed++;
    cyc();
    mem_resp = 1'b0;
    #1;
    total++;
    if (i_resp !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL i_done resp %b rd %b want 0 0", i_resp, mem_read);
    else passed++;
  endtask

  task automatic test_d_write();
    cyc();
    d_write = 1'b1;
    d_addr = 32'h1000;
    d_wdata = LINE_WB;
    cyc();
    #1;
    total++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h1000
        || mem_wdata !== LINE_WB)
      $display("FAIL d_wr wr %b rd %b addr %h want 1 0 1000",
               mem_write, mem_read, mem_addr);
    else passed++;
    d_write = 1'b0;
    d_wdata = '0;
    cyc();
    cyc();
    mem_resp = 1'b1;
    #1;
    total++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0)
      $display("FAIL d_wr_resp d %b i %b want 1 0", d_resp, i_resp);
    else passed++;
    cyc();
    mem_resp = 1'b0;
    #1;
    total++;
    if (d_resp !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL d_wr_done resp %b wr %b want 0 0", d_resp, mem_write);
    else passed++;
  endtask

  task automatic test_rw_conflict();
    cyc();
    d_read = 1'b1;
    d_write = 1'b1;
    d_addr = 32'h1040;
    cyc();
    #1;
    total++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0)
      $display("FAIL rw_conf wr %b rd %b want 1 0", mem_write, mem_read);
    else passed++;
    d_read = 1'b0;
    d_write = 1'b0;
    cyc();
    mem_resp = 1'b1;
    cyc();
    mem_resp = 1'b0;
  endtask

  task automatic test_simultaneous();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    i_read = 1'b1;
    i_addr = 32'h80;
    d_read = 1'b1;
    d_addr = 32'h2000;
    cyc();
    #1;
    total++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h2000)
      $display("FAIL sim_first rd %b addr %h want 1 2000", mem_read, mem_addr);
    else passed++;
    d_read = 1'b0;
    cyc();
    mem_resp = 1'b1;
    mem_rdata = LINE_5A;
    #1;
    total++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== LINE_5A)
      $display("FAIL sim_dresp d %b i %b want 1 0", d_resp, i_resp);
    else passed++;
    cyc();
    mem_resp = 1'b0;
    #1;
    total++;
    if (mem_read !== 1'b0)
      $display("FAIL sim_gap rd %b want 0", mem_read);
    else passed++;
    cyc();
    #1;
    total++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h80)
      $display("FAIL sim_second rd %b addr %h want 1 80", mem_read, mem_addr);
    else passed++;
    i_read = 1'b0;
    cyc();
    mem_resp = 1'b1;
    #1;
    total++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0)
      $display("FAIL sim_iresp i %b d %b want 1 0", i_resp, d_resp);
    else passed++;
    cyc();
    mem_resp = 1'b0;
  endtask

  task automatic test_alternate();
    logic [31:0] exp_addr;
    bit ok;
    bit exp_d;
    i_read = 1'b1;
    i_addr = 32'h100;
    d_read = 1'b1;
    d_addr = 32'h4000;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2 == 0);
      exp_addr = exp_d ? 32'h4000 : 32'h100;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        cyc();
        #1;
        if (mem_read) ok = 1'b1;
      end
      total++;
      if (!ok)
        $display("FAIL alt_wait%0d no request within 20 cycles", t);
      else if (mem_addr !== exp_addr)
        $display("FAIL alt_addr%0d got %h want %h", t, mem_addr, exp_addr);
      else passed++;
      cyc();
      mem_resp = 1'b1;
      #1;
      total++;
      if (d_resp !== exp_d || i_resp !== !exp_d)
        $display("FAIL alt_resp%0d d %b i %b want %b %b",
                 t, d_resp, i_resp, exp_d, !exp_d);
      else passed++;
      cyc();
      mem_resp = 1'b0;
      if (t == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
    end
  endtask

  task automatic test_addr_stable();
    cyc();
    d_read = 1'b1;
    d_addr = 32'h2000;
    cyc();
    #1;
    d_addr = 32'h3000;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      total++;
      if (mem_addr !== 32'h2000 || mem_read !== 1'b1)
        $display("FAIL stable%0d addr %h rd %b want 2000 1", k, mem_addr, mem_read);
      else passed++;
    end
    cyc();
    mem_resp = 1'b1;
    #1;
    total++;
    if (mem_addr !== 32'h2000 || d_resp !== 1'b1)
      $display("FAIL stable_end addr %h resp %b want 2000 1", mem_addr, d_resp);
    else passed++;
    cyc();
    mem_resp = 1'b0;
    d_read = 1'b0;
  endtask

  task automatic test_reset_midflight();
    cyc();
    d_write = 1'b1;
    d_addr = 32'h5000;
    d_wdata = LINE_WB;
    cyc();
    #1;
    total++;
    if (mem_write !== 1'b1)
      $display("FAIL mid_start wr %b want 1", mem_write);
    else passed++;
    d_write = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    total++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0
        || mem_addr !== 32'h0 || mem_wdata !== 256'h0)
      $display("FAIL mid_rst ctl %b addr %h want 0000 0",
               {mem_read, mem_write, i_resp, d_resp}, mem_addr);
    else passed++;
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    mem_resp = 1'b1;
    #1;
    total++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0)
      $display("FAIL stray_resp i %b d %b want 0 0", i_resp, d_resp);
    else passed++;
    cyc();
    mem_resp = 1'b0;
    i_read = 1'b1;
    i_addr = 32'h40;
    cyc();
    #1;
    total++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h40)
      $display("FAIL post_rst rd %b addr %h want 1 40", mem_read, mem_addr);
    else passed++;
    i_read = 1'b0;
    cyc();
    mem_resp = 1'b1;
    mem_rdata = LINE_A5;
    #1;
    total++;
    if (i_resp !== 1'b1 || i_rdata !== LINE_A5 || d_resp !== 1'b0)
      $display("FAIL post_rst_resp i %b d %b", i_resp, d_resp);
    else passed++;
    cyc();
    mem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_rw_conflict();
    test_simultaneous();
    test_alternate();
    test_addr_stable();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-to-one arbiter between the instruction cache and data cache miss ports and the single physical-memory port (cacheline adaptor) below them. It sits directly downstream of the icache/dcache pair that the pipeline datapath drives. It accepts whole-line read/write requests from each cache, serialises them onto one memory port, and routes the line response back to the requester. Data misses win ties, but a pending instruction miss is always served next, so neither side starves.

## Interface
- LINE_WIDTH, 256, cacheline width in bits
- ADDR_WIDTH, 32, line address width in bits
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- i_read  input  1  icache line read request
- i_addr  input  ADDR_WIDTH  icache line address
- i_rdata  output  LINE_WIDTH  line returned to icache
- i_resp  output  1  icache request complete
- d_read  input  1  dcache line read request
- d_write  input  1  dcache line write-back request
- d_addr  input  ADDR_WIDTH  dcache line address
- d_wdata  input  LINE_WIDTH  dcache write-back line
- d_rdata  output  LINE_WIDTH  line returned to dcache
- d_resp  output  1  dcache request complete
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  LINE_WIDTH  memory write line
- mem_rdata  input  LINE_WIDTH  memory read line
- mem_resp  input  1  memory request complete

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE, at least one request pending:
  - Grant selection:
    - Only i_read pending → SERVE_I.
    - Only d_read or d_write pending → SERVE_D.
    - Both sides pending → SERVE_D, unless last_grant == D, then SERVE_I.
  - On the grant edge, latch the granted side's addr, wdata, read and write into the request register.
  - Record the granted side in last_grant.
- SERVE_x:
  - mem_read, mem_write, mem_addr and mem_wdata are driven only from the request register, so they are stable for the whole transaction even if the cache inputs change.
  - On mem_resp, the granted side's resp is asserted for that cycle and its rdata is a pass-through of mem_rdata. The next state is IDLE.
- i_rdata and d_rdata carry mem_rdata at all times. Only the resp strobes qualify them.
- A resp is never asserted to the non-granted side.
- mem_resp while in IDLE is ignored.
- d_read and d_write asserted together are illegal. If it happens, the arbiter treats the request as a write.
- A cache must deassert its request in the cycle after its resp. A request still held in that cycle is treated as a new request.
- Reset:
  - State → IDLE, last_grant → I, request register cleared.
  - All outputs → 0.
  - An in-flight memory transaction is abandoned and its later mem_resp is ignored.

## Timing
- Request present at cycle N in IDLE → mem_read/mem_write high at N+1. This is one cycle of arbitration latency; memory-side outputs are registered.
- mem_resp at cycle M → i_resp/d_resp high at M, same cycle (combinational). The FSM is IDLE at M+1.
- Back-to-back: a new request sampled at M+1 reaches memory at M+2.
- Minimum total turnaround is memory latency + 2 cycles.
- mem_read/mem_write drop at M+1, the cycle after mem_resp.
- A simultaneous request at the same edge that a resp completes is not sampled until the FSM reaches IDLE.

## Structure
- Shared package `arbiter_types`:
  - `arb_state_t` enum {IDLE, SERVE_I, SERVE_D}.
  - `arb_grant_t` enum {GRANT_I, GRANT_D}.
  - Line/address width constants.
- No sub-module. The block is one FSM plus one request register.

## Test plan
- Lone icache read, addr 0x0000_0040, memory responds after 5 cycles with line 0xA5…A5:
  - mem_read high 1 cycle after i_read, mem_addr 0x40.
  - i_resp high for 1 cycle with i_rdata 0xA5…A5.
  - d_resp stays 0.
- Lone dcache write, addr 0x0000_1000, wdata 0x1234…:
  - mem_write with exact addr/wdata.
  - mem_read stays 0.
  - d_resp high for one cycle.
- Simultaneous i_read (0x80) and d_read (0x2000) after reset:
  - dcache served first.
  - Icache served immediately after, with mem_addr 0x80.
  - Each resp goes only to its owner.
- Both caches held requesting continuously:
  - Grants alternate D, I, D, I.
  - No side waits more than one other transaction.
- Cache changes d_addr mid-transaction from 0x2000 to 0x3000 → mem_addr stays 0x2000 until mem_resp.
- rst pulsed low while SERVE_D waits on memory:
  - All outputs 0 immediately.
  - A stray mem_resp 3 cycles later produces no i_resp/d_resp.
  - The next i_read is served normally.
